// File: rtl/sm_divider_seq.sv
// Sequential restoring divider for sign-magnitude operands (sign in the MSB).
// One division per start; quotient and remainder are delivered with a done pulse.
module sm_divider_seq #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  output logic             busy,
  output logic             done,
  output logic [MAG_W:0]   quot,
  output logic [MAG_W:0]   rem,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where busy=0; done is a
  // one-cycle pulse and quot/rem/div_zero hold until the next done.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int CNT_W = $clog2(MAG_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAG_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [MAG_W-1:0] dvd_q, dvd_d;
  logic [MAG_W-1:0] dvs_q, dvs_d;
  logic [MAG_W:0]   part_q, part_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_quot_q, sign_quot_d;
  logic             sign_rem_q, sign_rem_d;
  logic [MAG_W:0]   quot_q, quot_d;
  logic [MAG_W:0]   rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [MAG_W:0]   r_shift;
  logic [MAG_W:0]   r_sub;
  logic [MAG_W:0]   r_next;
  logic             ge;
  logic [MAG_W-1:0] q_next;

  // Dividend register doubles as the quotient shift register.
  always_comb begin
    r_shift = {part_q[MAG_W-1:0], dvd_q[MAG_W-1]};
    r_sub   = r_shift - {1'b0, dvs_q};
    ge      = (r_shift >= {1'b0, dvs_q});
    r_next  = ge ? r_sub : r_shift;
    q_next  = {dvd_q[MAG_W-2:0], ge};
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d       = a[MAG_W-1:0];
          dvs_d       = b[MAG_W-1:0];
          sign_quot_d = a[MAG_W] ^ b[MAG_W];
          sign_rem_d  = a[MAG_W];
          if (b[MAG_W-1:0] == '0) begin
            quot_d  = {1'b0, {MAG_W{1'b1}}};
            rem_d   = {a[MAG_W] & (|a[MAG_W-1:0]), a[MAG_W-1:0]};
            dz_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            part_d  = '0;
            cnt_d   = CNT_LOAD;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        part_d = r_next;
        dvd_d  = q_next;
        cnt_d  = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          // Zero magnitudes never carry a sign bit.
          quot_d  = {sign_quot_q & (|q_next), q_next};
          rem_d   = {sign_rem_q & (|r_next[MAG_W-1:0]), r_next[MAG_W-1:0]};
          dz_d    = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sm_divider_seq.sv
// Directed bench for sm_divider_seq at MAG_W=2 and MAG_W=4: vector table plus
// hand-written sequences for ignored starts and asynchronous reset mid-division.
module tb_sm_divider_seq;

  logic       clk;
  logic       rst;
  logic       start2, start4;
  logic [2:0] a2, b2;
  logic [4:0] a4, b4;
  logic       busy2, done2, dz2;
  logic [2:0] quot2, rem2;
  logic       busy4, done4, dz4;
  logic [4:0] quot4, rem4;
  logic [1:0] st2, st4;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sm_divider_seq #(.MAG_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .quot(quot2), .rem(rem2),
    .div_zero(dz2), .dbg_state(st2)
  );

  sm_divider_seq #(.MAG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .quot(quot4), .rem(rem4),
    .div_zero(dz4), .dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         w;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] q;
    logic [4:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Start one division, scramble a/b after the start edge, wait for done.
  task automatic run_op(input int w, input logic [4:0] a, input logic [4:0] b,
                        output logic [4:0] q, output logic [4:0] r, output logic dz,
                        output int lat, output int bcyc);
    @(negedge clk);
    if (w == 2) begin
      a2 = a[2:0]; b2 = b[2:0]; start2 = 1'b1;
    end else begin
      a4 = a; b4 = b; start4 = 1'b1;
    end
    @(posedge clk); #1;
    start2 = 1'b0; start4 = 1'b0;
    a2 = 3'($urandom_range(0, 7));  b2 = 3'($urandom_range(0, 7));
    a4 = 5'($urandom_range(0, 31)); b4 = 5'($urandom_range(0, 31));
    lat = 1; bcyc = 0;
    while (lat <= 40) begin
      if ((w == 2) ? busy2 : busy4) bcyc++;
      if ((w == 2) ? done2 : done4) break;
      @(posedge clk); #1;
      lat++;
    end
    if (w == 2) begin
      q = {2'b00, quot2}; r = {2'b00, rem2}; dz = dz2;
    end else begin
      q = quot4; r = rem4; dz = dz4;
    end
    @(posedge clk); #1;
    chk($sformatf("w%0d busy_after_done", w), 32'((w == 2) ? busy2 : busy4), 32'd0);
    chk($sformatf("w%0d done_pulse_width", w), 32'((w == 2) ? done2 : done4), 32'd0);
  endtask

  initial begin
    logic [4:0] q, r;
    logic       dz;
    int         lat, bcyc, dcnt;

    // {w, a, b, quot, rem, div_zero, latency}
    vecs[0]  = '{2, 5'b00011, 5'b00001, 5'b00011, 5'b00000, 1'b0, 3};
    vecs[1]  = '{2, 5'b00111, 5'b00010, 5'b00101, 5'b00101, 1'b0, 3};
    vecs[2]  = '{2, 5'b00010, 5'b00111, 5'b00000, 5'b00010, 1'b0, 3};
    vecs[3]  = '{2, 5'b00011, 5'b00100, 5'b00011, 5'b00011, 1'b1, 1};
    vecs[4]  = '{2, 5'b00010, 5'b00001, 5'b00010, 5'b00000, 1'b0, 3};
    vecs[5]  = '{2, 5'b00100, 5'b00001, 5'b00000, 5'b00000, 1'b0, 3};
    vecs[6]  = '{2, 5'b00110, 5'b00011, 5'b00000, 5'b00110, 1'b0, 3};
    vecs[7]  = '{2, 5'b00101, 5'b00000, 5'b00011, 5'b00101, 1'b1, 1};
    vecs[8]  = '{2, 5'b00100, 5'b00000, 5'b00011, 5'b00000, 1'b1, 1};
    vecs[9]  = '{2, 5'b00111, 5'b00001, 5'b00111, 5'b00000, 1'b0, 3};
    vecs[10] = '{4, 5'b01111, 5'b00100, 5'b00011, 5'b00011, 1'b0, 5};
    vecs[11] = '{4, 5'b11101, 5'b00011, 5'b10100, 5'b10001, 1'b0, 5};
    vecs[12] = '{4, 5'b01001, 5'b11010, 5'b00000, 5'b01001, 1'b0, 5};
    vecs[13] = '{4, 5'b11111, 5'b10001, 5'b01111, 5'b00000, 1'b0, 5};
    vecs[14] = '{4, 5'b01100, 5'b00000, 5'b01111, 5'b01100, 1'b1, 1};

    rst = 1'b1; start2 = 1'b0; start4 = 1'b0;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    chk("rst busy2", 32'(busy2), 32'd0);
    chk("rst done2", 32'(done2), 32'd0);
    chk("rst quot2", 32'(quot2), 32'd0);
    chk("rst rem2",  32'(rem2),  32'd0);
    chk("rst dz2",   32'(dz2),   32'd0);
    chk("rst busy4", 32'(busy4), 32'd0);
    chk("rst quot4", 32'(quot4), 32'd0);
    chk("rst dz4",   32'(dz4),   32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, q, r, dz, lat, bcyc);
      chk($sformatf("v%0d quot", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d rem", i),  32'(r), 32'(vecs[i].r));
      chk($sformatf("v%0d dz", i),   32'(dz), 32'(vecs[i].dz));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d busy_cycles", i), 32'(bcyc), 32'(vecs[i].lat));
    end

    // start held during CALC and FIN of a 15/4 division must be ignored
    @(negedge clk);
    a4 = 5'b01111; b4 = 5'b00100; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; lat = 1; dcnt = 0;
    @(posedge clk); #1;
    lat = 2;
    a4 = 5'b00111; b4 = 5'b00010; start4 = 1'b1;
    while (lat <= 40) begin
      if (done4) break;
      @(posedge clk); #1;
      lat++;
    end
    if (done4) dcnt++;
    chk("ign latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) dcnt++;
    end
    chk("ign done_count", 32'(dcnt), 32'd1);
    chk("ign quot", 32'(quot4), 32'b00011);
    chk("ign rem",  32'(rem4),  32'b00011);
    chk("ign busy", 32'(busy4), 32'd0);

    // asynchronous reset in the middle of CALC
    run_op(2, 5'b00011, 5'b00100, q, r, dz, lat, bcyc);
    chk("pre_rst dz", 32'(dz), 32'd1);
    @(negedge clk);
    a2 = 3'b011; b2 = 3'b001; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    chk("mid busy", 32'(busy2), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy2), 32'd0);
    chk("arst done", 32'(done2), 32'd0);
    chk("arst quot", 32'(quot2), 32'd0);
    chk("arst rem",  32'(rem2),  32'd0);
    chk("arst dz",   32'(dz2),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done2) dcnt++;
    end
    chk("arst no_done", 32'(dcnt), 32'd0);
    run_op(2, 5'b00011, 5'b00001, q, r, dz, lat, bcyc);
    chk("post_rst quot", 32'(q), 32'b00011);
    chk("post_rst rem",  32'(r), 32'b00000);
    chk("post_rst dz",   32'(dz), 32'd0);
    chk("post_rst latency", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
